// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage constants: reset PC default, nop encoding, FSM states.
// Pure declarations, no logic.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_pc_reg.sv
// Fetch PC register: reset value, word-aligned redirect (highest priority), +4 advance.
// Zero-latency combinational next-pc; value visible the cycle after update.
module ifu_fetch_pc_reg
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {target_i[XLEN-1:2], 2'b00};
        end else if (advance_i) begin
            // Wraps silently at the top of the address space.
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Single-issue fetch: one outstanding imem read, word handed to decode over valid/ready.
// Accept at t, rsp at t+k, inst_valid from t+k+1; decode stall holds the word and blocks new fetches.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_e    state_q, state_d;
    logic            drop_q, drop_d;
    logic            inst_vld_q, inst_vld_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] pc;
    logic            advance;
    logic            req_hs;

    ifu_fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect_i (redirect_valid),
        .target_i   (redirect_pc),
        .advance_i  (advance),
        .pc_o       (pc)
    );

    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_req_addr  = pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        inst_vld_d = inst_vld_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        advance    = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (req_hs) begin
                    state_d = S_WAIT;
                    // A redirect racing the handshake makes the in-flight word stale.
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d     = imem_rsp_data[31:0];
                        inst_pc_d  = pc;
                        inst_vld_d = 1'b1;
                        advance    = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    inst_vld_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            drop_q     <= 1'b0;
            inst_vld_q <= 1'b0;
            inst_q     <= NOP_INSN;
            inst_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            inst_vld_q <= inst_vld_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    assign inst_valid = inst_vld_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, hand-written corner sequences,
// then randomized traffic against a program-order fetch scoreboard.
module tb_ifu_fetch;

    localparam logic [31:0] R   = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          NV  = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic        rstn;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ir;
        int          k;
        logic        chk;
        logic        ci;
        logic        e_reqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t        tbl[NV];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pend    = 0;
    logic [31:0] pend_addr = 32'h0;

    logic [31:0] exp_pc;
    int          n_dlv;
    int          r_rdy, r_rv, r_ir;
    logic [31:0] r_pc;
    logic        prev_iv, prev_ir, prev_rv;
    logic [31:0] prev_inst, prev_ipc;

    // Memory contents: a fixed scramble of the address so every word is distinct.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input int rstn, input int rdy, input int rv,
                                input logic [31:0] rpc, input int ir, input int k,
                                input int chk, input int ci, input int reqv,
                                input logic [31:0] addr, input int iv,
                                input logic [31:0] ipc, input logic [31:0] iw);
        vec_t v;
        v.rstn = (rstn != 0); v.rdy = (rdy != 0); v.rv = (rv != 0); v.rpc = rpc;
        v.ir = (ir != 0); v.k = k; v.chk = (chk != 0); v.ci = (ci != 0);
        v.e_reqv = (reqv != 0); v.e_addr = addr; v.e_iv = (iv != 0);
        v.e_ipc = ipc; v.e_inst = iw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the negedge; the memory model answers k cycles after accept.
    task automatic drive(input int rstn, input int rdy, input int rv,
                         input logic [31:0] rpc, input int ir);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (rstn == 0) begin
            pend = 0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(pend_addr);
            end
        end
        rst_n          = (rstn != 0);
        imem_req_ready = (rdy != 0);
        redirect_valid = (rv != 0);
        redirect_pc    = rpc;
        inst_ready     = (ir != 0);
        #1;
    endtask

    task automatic accept(input int k);
        if (imem_req_valid && imem_req_ready) begin
            pend      = k;
            pend_addr = imem_req_addr;
        end
    endtask

    initial begin
        tbl[0]  = mk(0,0,0,0,0,1, 0,0, 0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,1, 1,1, 0,R,0,0,NOP);
        tbl[2]  = mk(1,1,0,0,1,1, 1,0, 1,R,0,0,0);
        tbl[3]  = mk(1,1,0,0,1,1, 1,0, 0,R,0,0,0);
        tbl[4]  = mk(1,1,0,0,1,1, 1,1, 0,R+4,1,R,memf(R));
        tbl[5]  = mk(1,1,0,0,1,1, 1,0, 1,R+4,0,0,0);
        tbl[6]  = mk(1,1,0,0,1,1, 1,0, 0,R+4,0,0,0);
        tbl[7]  = mk(1,1,0,0,1,1, 1,1, 0,R+8,1,R+4,memf(R+4));
        tbl[8]  = mk(1,1,0,0,1,1, 1,0, 1,R+8,0,0,0);
        tbl[9]  = mk(1,1,0,0,1,1, 1,0, 0,R+8,0,0,0);
        for (int i = 10; i < 15; i++)
            tbl[i] = mk(1,1,0,0,0,1, 1,1, 0,R+12,1,R+8,memf(R+8));
        tbl[15] = mk(1,1,0,0,1,1, 1,1, 0,R+12,1,R+8,memf(R+8));
        tbl[16] = mk(1,1,0,0,1,4, 1,0, 1,R+12,0,0,0);
        tbl[17] = mk(1,1,1,R+'h100,1,1, 1,0, 0,R+12,0,0,0);
        for (int i = 18; i < 21; i++)
            tbl[i] = mk(1,1,0,0,1,1, 1,0, 0,R+'h100,0,0,0);
        tbl[21] = mk(1,1,0,0,1,1, 1,0, 1,R+'h100,0,0,0);
        tbl[22] = mk(1,1,0,0,1,1, 1,0, 0,R+'h100,0,0,0);
        tbl[23] = mk(1,1,1,32'h8000_0203,1,1, 1,1, 0,R+'h104,1,R+'h100,memf(R+'h100));
        tbl[24] = mk(1,1,1,32'h8000_0300,1,1, 1,0, 1,32'h8000_0200,0,0,0);
        tbl[25] = mk(1,1,0,0,1,1, 1,0, 0,32'h8000_0300,0,0,0);
        tbl[26] = mk(1,1,0,0,1,1, 1,0, 1,32'h8000_0300,0,0,0);
        tbl[27] = mk(1,1,0,0,1,1, 1,0, 0,32'h8000_0300,0,0,0);
        tbl[28] = mk(1,1,0,0,0,1, 1,1, 0,32'h8000_0304,1,32'h8000_0300,memf(32'h8000_0300));
        tbl[29] = mk(0,1,0,0,0,1, 1,1, 0,32'h8000_0304,1,32'h8000_0300,memf(32'h8000_0300));
        tbl[30] = mk(1,0,0,0,1,1, 1,1, 1,R,0,0,NOP);

        for (int i = 0; i < NV; i++) begin
            drive(int'(tbl[i].rstn), int'(tbl[i].rdy), int'(tbl[i].rv), tbl[i].rpc, int'(tbl[i].ir));
            if (tbl[i].chk) begin
                check($sformatf("vec%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_reqv});
                check($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
                check($sformatf("vec%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_iv});
                if (tbl[i].ci) begin
                    check($sformatf("vec%0d inst", i), inst, tbl[i].e_inst);
                    check($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
                end
            end
            accept(tbl[i].k);
        end

        // PC wrap at the top of the address space.
        drive(1, 0, 1, 32'hFFFF_FFFC, 1); accept(1);
        drive(1, 1, 0, 0, 1);
        check("wrap req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("wrap req_addr", imem_req_addr, 32'hFFFF_FFFC);
        accept(1);
        drive(1, 0, 0, 0, 0); accept(1);
        drive(1, 0, 0, 0, 0);
        check("wrap inst_valid", {31'b0, inst_valid}, 32'd1);
        check("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap inst", inst, memf(32'hFFFF_FFFC));
        check("wrap next_pc", imem_req_addr, 32'h0000_0000);
        drive(1, 0, 0, 0, 1); accept(1);
        drive(1, 0, 0, 0, 0);
        check("wrap next_req", imem_req_addr, 32'h0000_0000);

        // Redirect in the same cycle the response arrives.
        drive(1, 1, 0, 0, 0); accept(2);
        drive(1, 0, 0, 0, 0); accept(1);
        drive(1, 0, 1, 32'h0000_1002, 0); accept(1);
        drive(1, 0, 0, 0, 0);
        check("rsp_redirect inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rsp_redirect req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rsp_redirect req_addr", imem_req_addr, 32'h0000_1000);

        // Random traffic: fetch addresses and delivered words must follow program order.
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        exp_pc  = R;
        n_dlv   = 0;
        prev_iv = 1'b0; prev_ir = 1'b0; prev_rv = 1'b0;
        prev_inst = 32'h0; prev_ipc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r_rdy = ($urandom_range(0, 9) < 7) ? 1 : 0;
            r_rv  = ($urandom_range(0, 99) < 8) ? 1 : 0;
            r_ir  = ($urandom_range(0, 9) < 6) ? 1 : 0;
            r_pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            drive(1, r_rdy, r_rv, r_pc, r_ir);
            if (prev_iv && !prev_rv && !prev_ir) begin
                check("rand hold_valid", {31'b0, inst_valid}, 32'd1);
                check("rand hold_inst", inst, prev_inst);
                check("rand hold_pc", inst_pc, prev_ipc);
            end else if (prev_iv) begin
                check("rand valid_clears", {31'b0, inst_valid}, 32'd0);
            end
            if (imem_req_valid && imem_req_ready) begin
                check("rand one_outstanding", 32'(pend), 32'd0);
                check("rand req_addr", imem_req_addr, exp_pc);
            end
            if (inst_valid && inst_ready) begin
                check("rand inst_pc", inst_pc, exp_pc);
                check("rand inst", inst, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_dlv++;
            end
            if (r_rv != 0) exp_pc = {r_pc[31:2], 2'b00};
            prev_iv = inst_valid; prev_ir = inst_ready; prev_rv = redirect_valid;
            prev_inst = inst; prev_ipc = inst_pc;
            accept(int'($urandom_range(1, 4)));
        end
        check("rand progress", (n_dlv >= 100) ? 32'd1 : 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
